bus_transfer_ctrl: RTL and testbench
====================================

# bus_transfer_ctrl

Sequencer that moves data between general-purpose registers over the shared 16-bit processor bus. It sits directly upstream and downstream of each register block (R1..Rn): it drives their LDBUS, WR, INC and per-register clear strobes, captures their BOUT outputs onto a registered bus, and feeds that bus back to every register's BIN. Transfers are requested by the control unit with a REQ/BUSY/DONE handshake. One transfer is in flight at a time.

## Interface
- WIDTH, 16, bus and register data width
- NREG, 8, number of attached registers; SRC and DST widths are clog2(NREG)
- clk  input  1  system clock, rising-edge active
- RSTn  input  1  asynchronous, active-low reset
- REQ  input  1  transfer request, sampled only in IDLE
- OP  input  2  operation: 00 MOVE, 01 INC, 10 CLR, 11 NOP
- SRC  input  clog2(NREG)  source register index (MOVE, INC)
- DST  input  clog2(NREG)  destination register index (MOVE, CLR)
- RIN  input  NREG*WIDTH  packed register BOUT values; register i occupies bits [i*WIDTH +: WIDTH]
- BUS  output  WIDTH  registered bus value, wired to every register's BIN
- LDBUS  output  NREG  one-hot load-to-output strobe
- WR  output  NREG  one-hot write-from-bus strobe
- INC  output  NREG  one-hot increment strobe
- CLR  output  NREG  one-hot per-register clear strobe (the register's RST2)
- BUSY  output  1  high whenever the state is not IDLE
- DONE  output  1  one-cycle pulse in the final cycle of each operation

## Operation
- States: IDLE, LOAD, CAPT, WRITE, INCS, CLRS, NOPS.
- IDLE: if REQ=1 at a rising edge, latch OP, SRC and DST into internal registers, then go to:
  - OP=00: LOAD
  - OP=01: INCS
  - OP=10: CLRS
  - OP=11: NOPS
- IDLE with REQ=0: stay in IDLE.
- LOAD: LDBUS[src]=1 → CAPT.
- CAPT: all strobes low; at the end of the cycle BUS <= RIN[src] → WRITE.
- WRITE: WR[dst]=1, DONE=1, BUS held → IDLE.
- INCS: INC[src]=1, DONE=1 → IDLE.
- CLRS: CLR[dst]=1, DONE=1 → IDLE.
- NOPS: DONE=1, no strobes → IDLE.
- All strobe outputs are Moore outputs decoded from the state and the latched indices. At most one bit across LDBUS, WR, INC and CLR is high in any cycle.
- REQ, OP, SRC and DST are ignored while BUSY=1. Changing the inputs mid-transfer has no effect.
- BUS changes only at the CAPT→WRITE edge and on reset. It holds its value otherwise, including across INC, CLR and NOP.
- Index ≥ NREG (non-power-of-two NREG): no strobe asserts, BUS captures 0, DONE still pulses.
- MOVE with SRC==DST is legal. The register is reloaded with its own value.
- Reset (RSTn=0, any time, including mid-transfer):
  - state goes to IDLE
  - BUS, LDBUS, WR, INC, CLR, BUSY and DONE go to 0 immediately (asynchronous)
  - latched OP, SRC and DST go to 0
- On RSTn release, the first REQ is accepted at the first rising edge with RSTn=1.

## Timing
- MOVE: REQ accepted at edge E0.
  - E0–E1: LOAD
  - E1–E2: CAPT; the register's BOUT is valid after E1
  - BUS valid from E2
  - E2–E3: WRITE; the destination register writes BUS at E3
  - BUSY is high for 3 cycles.
- INC, CLR, NOP: BUSY and DONE are high for 1 cycle (E0–E1). The target register acts at E1.
- Back-to-back operation: REQ held high in the DONE cycle is sampled at the return to IDLE, not earlier. The minimum gap between accepted requests is 1 IDLE cycle.
- DONE is never high for two consecutive cycles.

## Test plan
- Reset mid-MOVE:
  - Stimulus: pull RSTn low during CAPT.
  - Required: all outputs read 0 within the same cycle; state is IDLE after release; no WR pulse ever appears.
- MOVE R3→R5, with R3 BOUT=16'd35 after LDBUS:
  - LDBUS=8'b0000_1000 for exactly 1 cycle
  - BUS=35 from E2
  - WR=8'b0010_0000 and DONE=1 in E2–E3
  - BUSY high for exactly 3 cycles
- INC R2 twice (second REQ asserted in the IDLE cycle after DONE):
  - INC=8'b0000_0100 for 1 cycle each time
  - BUS unchanged
  - attached R2 increments from 0 to 2
- CLR R7 after MOVE R0→R7 (R0=16'hABCD):
  - R7 reads 16'hABCD, then 0 after CLR
  - CLR=8'b1000_0000 for 1 cycle
  - BUS stays 16'hABCD
- REQ toggled and OP, SRC, DST changed during a MOVE (BUSY=1):
  - the original transfer completes unaltered
  - no extra strobes appear
  - DONE pulses once
- OP=11 and MOVE R4→R4 (R4=16'h00FF):
  - NOP gives DONE only, all strobes 0
  - self-move ends with R4 still 16'h00FF and BUS=16'h00FF

Source files
------------

// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: sequences register-to-register transfers over the shared
// processor bus. The control unit issues MOVE / INC / CLR / NOP requests; this
// block drives the one-hot register strobes, captures the source register's
// BOUT into a registered BUS, and raises BUSY/DONE around each operation.
//
// Handshake: REQ is sampled only while the FSM is idle (BUSY=0). A request is
// accepted on the rising edge where REQ=1 and BUSY=0; OP/SRC/DST are latched on
// that same edge and ignored afterwards. DONE pulses for exactly one cycle in the
// last cycle of the operation, and BUSY falls on the following edge, so a REQ
// held high through DONE is accepted one idle cycle later.
module bus_transfer_ctrl #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic                    REQ,
    input  logic [1:0]              OP,
    input  logic [IW-1:0]           SRC,
    input  logic [IW-1:0]           DST,
    input  logic [NREG*WIDTH-1:0]   RIN,
    output logic [WIDTH-1:0]        BUS,
    output logic [NREG-1:0]         LDBUS,
    output logic [NREG-1:0]         WR,
    output logic [NREG-1:0]         INC,
    output logic [NREG-1:0]         CLR,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [2:0]              fsm_state
);

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_INCS  = 3'd4,
        S_CLRS  = 3'd5,
        S_NOPS  = 3'd6
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [IW-1:0]   src_q;
    logic [IW-1:0]   dst_q;

    // One-hot decode; an index outside 0..NREG-1 yields no strobe at all.
    function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREG-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IW'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Source word select; an out-of-range index reads as zero.
    function automatic logic [WIDTH-1:0] rin_sel(input logic [IW-1:0] idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IW'(i)) r = RIN[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    assign fsm_state = state;

    // Transfer FSM; strobes, BUSY and DONE are registered so each one is the
    // decode of the state being entered and the latched indices.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
            op_q  <= '0;
            src_q <= '0;
            dst_q <= '0;
            BUS   <= '0;
            LDBUS <= '0;
            WR    <= '0;
            INC   <= '0;
            CLR   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            LDBUS <= '0;
            WR    <= '0;
            INC   <= '0;
            CLR   <= '0;
            DONE  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ) begin
                        op_q  <= OP;
                        src_q <= SRC;
                        dst_q <= DST;
                        BUSY  <= 1'b1;
                        case (OP)
                            OP_MOVE: begin
                                state <= S_LOAD;
                                LDBUS <= onehot(SRC);
                            end
                            OP_INC: begin
                                state <= S_INCS;
                                INC   <= onehot(SRC);
                                DONE  <= 1'b1;
                            end
                            OP_CLR: begin
                                state <= S_CLRS;
                                CLR   <= onehot(DST);
                                DONE  <= 1'b1;
                            end
                            default: begin
                                state <= S_NOPS;
                                DONE  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    // Only a MOVE can be in LOAD; anything else is a corrupted
                    // state and is abandoned back to idle.
                    if (op_q == OP_MOVE) begin
                        state <= S_CAPT;
                    end else begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                S_CAPT: begin
                    // Source BOUT has been valid since LOAD ended; latch it and
                    // present it to the destination in the write cycle.
                    BUS   <= rin_sel(src_q);
                    state <= S_WRITE;
                    WR    <= onehot(dst_q);
                    DONE  <= 1'b1;
                end
                S_WRITE, S_INCS, S_CLRS, S_NOPS: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench for bus_transfer_ctrl with a behavioural model of the attached register
// blocks. Each request pushes its hand-computed response into expected queues;
// a negedge monitor accumulates the strobes seen across each transfer and
// compares them against the queue head when DONE appears.
module tb_bus_transfer_ctrl;

    localparam int WIDTH = 16;
    localparam int NREG  = 8;

    logic                  clk;
    logic                  RSTn;
    logic                  REQ;
    logic [1:0]            OP;
    logic [2:0]            SRC;
    logic [2:0]            DST;
    logic [NREG*WIDTH-1:0] RIN;
    logic [WIDTH-1:0]      BUS;
    logic [NREG-1:0]       LDBUS;
    logic [NREG-1:0]       WR;
    logic [NREG-1:0]       INC;
    logic [NREG-1:0]       CLR;
    logic                  BUSY;
    logic                  DONE;
    logic [2:0]            fsm_state;

    bus_transfer_ctrl #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk(clk), .RSTn(RSTn), .REQ(REQ), .OP(OP), .SRC(SRC), .DST(DST),
        .RIN(RIN), .BUS(BUS), .LDBUS(LDBUS), .WR(WR), .INC(INC), .CLR(CLR),
        .BUSY(BUSY), .DONE(DONE), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- attached register model ----------------
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] bout [NREG];
    logic             preset_en;
    int               preset_idx;
    logic [WIDTH-1:0] preset_val;

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (preset_en && preset_idx == i) regs[i] <= preset_val;
            else if (CLR[i])                  regs[i] <= '0;
            else if (WR[i])                   regs[i] <= BUS;
            else if (INC[i])                  regs[i] <= regs[i] + 16'd1;
            if (LDBUS[i]) bout[i] <= regs[i];
        end
    end

    always_comb begin
        RIN = '0;
        for (int i = 0; i < NREG; i++) RIN[i*WIDTH +: WIDTH] = bout[i];
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_sig_q [$];
    logic [15:0] exp_bus_q [$];
    logic [11:0] exp_meta_q[$];   // {busy_len, strobe_bits, max_per_cycle}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [31:0] acc_sig = '0;
    int          acc_pc  = 0;
    int          acc_max = 0;
    int          acc_len = 0;
    logic        prev_done = 1'b0;
    logic [31:0] idle_strb = '0;
    logic        stray_done = 1'b0;

    always @(negedge clk) begin : monitor
        logic [31:0] cur, s, e_sig;
        logic [15:0] e_bus;
        logic [11:0] e_meta;
        int c, p, m, l;
        cur = {CLR, INC, WR, LDBUS};
        c = $countones(cur);
        if (!RSTn) begin
            acc_sig   <= '0;
            acc_pc    <= 0;
            acc_max   <= 0;
            acc_len   <= 0;
            prev_done <= 1'b0;
        end else begin
            if (BUSY) begin
                s = acc_sig | cur;
                p = acc_pc + c;
                m = (acc_max > c) ? acc_max : c;
                l = acc_len + 1;
                if (DONE) begin
                    if (exp_sig_q.size() == 0) begin
                        check("unexpected_done", 64'(1), 64'(0));
                    end else begin
                        e_sig  = exp_sig_q.pop_front();
                        e_bus  = exp_bus_q.pop_front();
                        e_meta = exp_meta_q.pop_front();
                        check("strobe_set",    64'(s),         64'(e_sig));
                        check("strobe_bits",   64'(p),         64'(e_meta[7:4]));
                        check("max_per_cycle", 64'(m),         64'(e_meta[3:0]));
                        check("busy_len",      64'(l),         64'(e_meta[11:8]));
                        check("bus_at_done",   64'(BUS),       64'(e_bus));
                        check("done_gap",      64'(prev_done), 64'(0));
                    end
                    acc_sig <= '0;
                    acc_pc  <= 0;
                    acc_max <= 0;
                    acc_len <= 0;
                end else begin
                    acc_sig <= s;
                    acc_pc  <= p;
                    acc_max <= m;
                    acc_len <= l;
                end
            end else begin
                idle_strb  <= idle_strb | cur;
                stray_done <= stray_done | DONE;
            end
            prev_done <= DONE;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preset(input int idx, input logic [WIDTH-1:0] val);
        preset_en  = 1'b1;
        preset_idx = idx;
        preset_val = val;
        @(posedge clk); #1;
        preset_en  = 1'b0;
    endtask

    // Issues one request and waits (bounded) for the FSM to return to idle.
    task automatic do_op(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input bit perturb, input logic [31:0] e_sig,
                         input logic [15:0] e_bus, input logic [11:0] e_meta);
        bit idle;
        exp_sig_q.push_back(e_sig);
        exp_bus_q.push_back(e_bus);
        exp_meta_q.push_back(e_meta);
        REQ = 1'b1; OP = op; SRC = src; DST = dst;
        @(posedge clk); #1;
        REQ = 1'b0;
        idle = 1'b0;
        for (int k = 0; k < 8 && !idle; k++) begin
            if (!BUSY) begin
                idle = 1'b1;
            end else begin
                if (perturb) begin
                    REQ = ~REQ;
                    OP  = 2'($urandom_range(0, 3));
                    SRC = 3'($urandom_range(0, 7));
                    DST = 3'($urandom_range(0, 7));
                end
                @(posedge clk); #1;
            end
        end
        REQ = 1'b0;
        check("idle_reached", 64'(BUSY), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RSTn = 1'b0; REQ = 1'b0; OP = 2'b00; SRC = '0; DST = '0;
        preset_en = 1'b0; preset_idx = 0; preset_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({BUS, LDBUS, WR, INC, CLR, BUSY, DONE}), 64'(0));
        check("reset_state",   64'(fsm_state), 64'(0));

        preset(0, 16'hABCD);
        preset(1, 16'h1111);
        preset(2, 16'h0000);
        preset(3, 16'd35);
        preset(4, 16'h00FF);
        preset(5, 16'h5555);
        preset(6, 16'h6666);
        preset(7, 16'h7777);
        @(negedge clk);
        RSTn = 1'b1;
        @(posedge clk); #1;

        // Reset pulled during CAPT of MOVE R3->R5.
        REQ = 1'b1; OP = 2'b00; SRC = 3'd3; DST = 3'd5;
        @(posedge clk); #1;
        REQ = 1'b0;
        @(posedge clk); #2;
        RSTn = 1'b0;
        #1;
        check("midmove_rst_outputs", 64'({BUS, LDBUS, WR, INC, CLR, BUSY, DONE}), 64'(0));
        check("midmove_rst_state",   64'(fsm_state), 64'(0));
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("after_rst_state", 64'(fsm_state), 64'(0));
        check("r5_not_written",  64'(regs[5]),   64'(16'h5555));

        // MOVE R3->R5: LDBUS bit3, WR bit5, BUS=35.
        do_op(2'b00, 3'd3, 3'd5, 1'b0, 32'h0000_2008, 16'd35, 12'h321);
        check("r5_after_move", 64'(regs[5]), 64'(16'd35));

        // INC R2 twice, second request in the idle cycle after DONE.
        do_op(2'b01, 3'd2, 3'd0, 1'b0, 32'h0004_0000, 16'd35, 12'h111);
        do_op(2'b01, 3'd2, 3'd0, 1'b0, 32'h0004_0000, 16'd35, 12'h111);
        check("r2_after_inc2", 64'(regs[2]), 64'(16'd2));

        // MOVE R0->R7, then CLR R7.
        do_op(2'b00, 3'd0, 3'd7, 1'b0, 32'h0000_8001, 16'hABCD, 12'h321);
        check("r7_after_move", 64'(regs[7]), 64'(16'hABCD));
        do_op(2'b10, 3'd0, 3'd7, 1'b0, 32'h8000_0000, 16'hABCD, 12'h111);
        check("r7_after_clr", 64'(regs[7]), 64'(16'h0000));
        check("bus_after_clr", 64'(BUS), 64'(16'hABCD));

        // MOVE R4->R1 with REQ/OP/SRC/DST disturbed while busy.
        do_op(2'b00, 3'd4, 3'd1, 1'b1, 32'h0000_0210, 16'h00FF, 12'h321);
        check("r1_after_perturbed", 64'(regs[1]), 64'(16'h00FF));

        // NOP, then self-move R4->R4.
        do_op(2'b11, 3'd6, 3'd6, 1'b0, 32'h0000_0000, 16'h00FF, 12'h100);
        do_op(2'b00, 3'd4, 3'd4, 1'b0, 32'h0000_1010, 16'h00FF, 12'h321);
        check("r4_after_self", 64'(regs[4]), 64'(16'h00FF));
        check("bus_after_self", 64'(BUS), 64'(16'h00FF));

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_sig_q.size()), 64'(0));
        check("idle_strobes",  64'(idle_strb),        64'(0));
        check("stray_done",    64'(stray_done),       64'(0));
        check("r6_untouched",  64'(regs[6]),          64'(16'h6666));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
